// File: rtl/gol_pkg.sv
// Shared constants for the Game-of-Life VGA renderer: timing, board geometry,
// colour codes and the 8x8 live-cell icon.
package gol_pkg;

    localparam int unsigned GOL_LOG_W    = 4;
    localparam int unsigned GOL_LOG_H    = 4;
    localparam int unsigned GOL_CELL_LOG = 3;
    localparam int unsigned GOL_FRAME_X0 = 192;
    localparam int unsigned GOL_FRAME_Y0 = 224;
    localparam int unsigned GOL_H_ACTIVE = 640;
    localparam int unsigned GOL_H_TOTAL  = 800;
    localparam int unsigned GOL_V_TOTAL  = 525;

    localparam logic [5:0] COL_BLANK = 6'b00_00_00;
    localparam logic [5:0] COL_BG    = 6'b00_00_01;
    localparam logic [5:0] COL_DEAD  = 6'b01_01_01;
    localparam logic [5:0] COL_LIVE  = 6'b11_11_01;

    // Row iy occupies bits [8*iy+7 : 8*iy]; bit ix within the row is the pixel.
    localparam logic [63:0] GOL_ICON = {
        8'b0000_0000,   // row 7
        8'b0011_1100,   // row 6
        8'b0111_1110,   // row 5
        8'b0111_1110,   // row 4
        8'b0111_1110,   // row 3
        8'b0111_1110,   // row 2
        8'b0011_1100,   // row 1
        8'b0000_0000    // row 0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/gol_icon_rom.sv
// Combinational 8x8 live-cell icon lookup.
module gol_icon_rom
    import gol_pkg::*;
(
    input  logic [2:0] iy_i,
    input  logic [2:0] ix_i,
    output logic       bit_o
);

    assign bit_o = GOL_ICON[{iy_i, ix_i}];

endmodule

// File: rtl/gol_row_renderer.sv
// Prefetches one board row per horizontal blank into a double line buffer and
// renders cell icons through a 2-stage pixel pipeline.
module gol_row_renderer
    import gol_pkg::*;
#(
    parameter int unsigned LOG_W    = GOL_LOG_W,
    parameter int unsigned LOG_H    = GOL_LOG_H,
    parameter int unsigned CELL_LOG = GOL_CELL_LOG,
    parameter int unsigned FRAME_X0 = GOL_FRAME_X0,
    parameter int unsigned FRAME_Y0 = GOL_FRAME_Y0,
    parameter int unsigned H_ACTIVE = GOL_H_ACTIVE,
    parameter int unsigned H_TOTAL  = GOL_H_TOTAL,
    parameter int unsigned V_TOTAL  = GOL_V_TOTAL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic                   display_on,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    output logic                   rd_en,
    output logic [LOG_W+LOG_H-1:0] rd_addr,
    input  logic                   rd_data,
    output logic [5:0]             rgb,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   fetch_busy
);

    localparam int unsigned W = 1 << LOG_W;
    localparam int unsigned H = 1 << LOG_H;

    localparam logic [10:0] X0    = 11'(FRAME_X0);
    localparam logic [10:0] X1    = 11'(FRAME_X0 + (W << CELL_LOG));
    localparam logic [10:0] Y0    = 11'(FRAME_Y0);
    localparam logic [10:0] Y1    = 11'(FRAME_Y0 + (H << CELL_LOG));
    localparam logic [10:0] HACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HLAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLAST = 11'(V_TOTAL - 1);
    localparam logic [LOG_W-1:0] COL_LAST = LOG_W'(W - 1);

    logic [10:0] x, y, nxt_y;
    logic        nxt_in_frame, in_frame;

    assign x = {1'b0, hpos};
    assign y = {1'b0, vpos};

    always_comb begin
        nxt_y        = (y == VLAST) ? '0 : y + 11'd1;
        nxt_in_frame = (nxt_y >= Y0) && (nxt_y < Y1);
        in_frame     = (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
    end

    // ---------------- row fetch FSM ----------------
    fetch_state_e     state_q, state_d;
    logic [LOG_W-1:0] col_q, col_d;
    logic [LOG_H-1:0] row_q, row_d;
    logic             wr_en_q;
    logic [LOG_W-1:0] wr_col_q;
    logic             done_q;
    logic [W-1:0]     fill_buf_q;
    logic [W-1:0]     show_buf_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((x == HACT) && nxt_in_frame) begin
                    state_d = ST_FETCH;
                    row_d   = LOG_H'((nxt_y - Y0) >> CELL_LOG);
                    col_d   = '0;
                end
            end
            ST_FETCH: begin
                col_d = col_q + 1'b1;
                if (col_q == COL_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign rd_en      = (state_q == ST_FETCH);
    assign rd_addr    = {row_q, col_q};
    assign fetch_busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_col_q   <= '0;
            done_q     <= 1'b0;
            fill_buf_q <= '0;
            show_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            wr_en_q  <= rd_en;
            wr_col_q <= col_q;
            // Read data lags the strobe by one cycle, so the write uses the delayed column.
            if (wr_en_q) fill_buf_q[wr_col_q] <= rd_data;
            if (x == HLAST) begin
                if (done_q) show_buf_q <= fill_buf_q;
                done_q <= 1'b0;
            end else if (state_q == ST_DRAIN) begin
                done_q <= 1'b1;
            end
        end
    end

    // ---------------- render pipeline ----------------
    logic             s1_in_frame_q, s1_disp_q, s1_hs_q, s1_vs_q;
    logic [LOG_W-1:0] s1_col_q, s1_col_d;
    logic [2:0]       s1_ix_q, s1_iy_q;
    logic             icon_bit, px;
    logic [5:0]       rgb_q, rgb_d;
    logic             hs_q, vs_q;

    always_comb begin
        s1_col_d = in_frame ? LOG_W'((x - X0) >> CELL_LOG) : '0;
    end

    gol_icon_rom u_icon (
        .iy_i  (s1_iy_q),
        .ix_i  (s1_ix_q),
        .bit_o (icon_bit)
    );

    always_comb begin
        px    = show_buf_q[s1_col_q] & icon_bit;
        rgb_d = COL_BLANK;
        if (!s1_disp_q)         rgb_d = COL_BLANK;
        else if (!s1_in_frame_q) rgb_d = COL_BG;
        else                    rgb_d = px ? COL_LIVE : COL_DEAD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_in_frame_q <= 1'b0;
            s1_disp_q     <= 1'b0;
            s1_hs_q       <= 1'b0;
            s1_vs_q       <= 1'b0;
            s1_col_q      <= '0;
            s1_ix_q       <= '0;
            s1_iy_q       <= '0;
            rgb_q         <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
        end else begin
            s1_in_frame_q <= in_frame;
            s1_disp_q     <= display_on;
            s1_hs_q       <= hsync_in;
            s1_vs_q       <= vsync_in;
            s1_col_q      <= s1_col_d;
            s1_ix_q       <= hpos[2:0];
            s1_iy_q       <= vpos[2:0];
            rgb_q         <= rgb_d;
            hs_q          <= s1_hs_q;
            vs_q          <= s1_vs_q;
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;

endmodule
